// File: rtl/tomasulo_pkg.sv
// Shared types and widths for the Tomasulo execution units and the CDB.
package tomasulo_pkg;
    localparam int TAG_W = 6;
    localparam int XLEN  = 32;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mul_func_t;
endpackage

// File: rtl/result_fifo.sv
// In-order result buffer: 1-cycle write-to-head latency, push and pop allowed on the same edge.
// No internal backpressure; the producer's credit scheme must keep pushes within DEPTH.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 38
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
endmodule

// File: rtl/mul_exec_unit.sv
// RV32M multiply unit: LATENCY pipeline stages into a result buffer, publish on CDB request/grant.
// Accept-to-publish is LATENCY+1 cycles; ex_done is withheld once pipeline plus buffer hold RB_DEPTH ops.
module mul_exec_unit
    import tomasulo_pkg::*;
#(
    parameter int LATENCY  = 3,
    parameter int RB_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [XLEN-1:0]  issue_op1,
    input  logic [XLEN-1:0]  issue_op2,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic [1:0]       issue_func,
    output logic             ex_done,
    output logic             cdb_req,
    input  logic             cdb_grant,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [XLEN-1:0]  cdb_data,
    output logic             cdb_data_valid
);
    localparam int CW = $clog2(RB_DEPTH + 1);

    logic [CW-1:0]        cnt;
    logic                 pop;
    mul_func_t            func;
    logic                 sx1;
    logic                 sx2;
    logic [2*XLEN-1:0]    op1_ext;
    logic [2*XLEN-1:0]    op2_ext;
    logic [2*XLEN-1:0]    prod;

    logic [LATENCY-1:0]   stg_vld;
    logic [2*XLEN-1:0]    stg_prod [LATENCY];
    logic [TAG_W-1:0]     stg_tag  [LATENCY];
    mul_func_t            stg_func [LATENCY];

    logic [XLEN-1:0]      last_res;
    logic [TAG_W+XLEN-1:0] rb_head;
    logic                 rb_empty;
    logic                 rb_full;

    assign cdb_req        = !rst & !rb_empty;
    assign cdb_data_valid = cdb_req & cdb_grant;
    assign pop            = cdb_data_valid;
    // A pop in this cycle frees the slot the new op will eventually need.
    assign ex_done        = !rst & issue_valid & ((cnt < CW'(RB_DEPTH)) | cdb_data_valid);
    assign cdb_tag        = cdb_req ? rb_head[XLEN +: TAG_W] : '0;
    assign cdb_data       = cdb_req ? rb_head[XLEN-1:0]      : '0;

    // Sign-extending to 64 bits keeps the low 64 product bits exact for every signedness mix.
    assign func    = mul_func_t'(issue_func);
    assign sx1     = (func == MULH) || (func == MULHSU);
    assign sx2     = (func == MULH);
    assign op1_ext = {{XLEN{sx1 & issue_op1[XLEN-1]}}, issue_op1};
    assign op2_ext = {{XLEN{sx2 & issue_op2[XLEN-1]}}, issue_op2};
    assign prod    = op1_ext * op2_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            stg_vld <= '0;
        end else begin
            cnt        <= cnt + CW'(ex_done) - CW'(pop);
            stg_vld[0] <= ex_done;
            for (int k = 1; k < LATENCY; k++) begin
                stg_vld[k] <= stg_vld[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        stg_prod[0] <= prod;
        stg_tag[0]  <= issue_tag;
        stg_func[0] <= func;
        for (int k = 1; k < LATENCY; k++) begin
            stg_prod[k] <= stg_prod[k-1];
            stg_tag[k]  <= stg_tag[k-1];
            stg_func[k] <= stg_func[k-1];
        end
    end

    assign last_res = (stg_func[LATENCY-1] == MUL) ? stg_prod[LATENCY-1][XLEN-1:0]
                                                   : stg_prod[LATENCY-1][2*XLEN-1:XLEN];

    result_fifo #(
        .DEPTH (RB_DEPTH),
        .WIDTH (TAG_W + XLEN)
    ) u_rb (
        .clk      (clk),
        .rst      (rst),
        .push     (stg_vld[LATENCY-1]),
        .push_dat ({stg_tag[LATENCY-1], last_res}),
        .pop      (pop),
        .head     (rb_head),
        .empty    (rb_empty),
        .full     (rb_full)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(rb_full && stg_vld[LATENCY-1] && !pop));
        end
    end
endmodule
